// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared widths and state encoding for the duty-level sequencer
package pwm_seq_pkg;
  localparam int LEVEL_W = 4;
  localparam int TIMER_W = 8;
  typedef enum logic [1:0] {HOME, IDLE, PULSE, GAP} state_t;
endpackage

// File: rtl/pwm_seq_timer.sv
// pwm_seq_timer: loadable down-counter that holds at zero and flags done there
module pwm_seq_timer
  import pwm_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);
  logic [TIMER_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= load ? load_val : (done ? cnt : cnt - 1'b1);
  assign done = cnt == '0;
endmodule

// File: rtl/pwm_seq.sv
// pwm_seq: steps the PWM duty to a requested level with spaced inc/dec pulses; define PWM_SEQ_HOME_EN to home to level 0 after reset
module pwm_seq
  import pwm_seq_pkg::*;
#(
  parameter int MAX_LEVEL  = 10,
  parameter int INIT_LEVEL = 5,
  parameter int PULSE_W    = 2,
  parameter int GAP_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] tgt_level,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  output logic               inc_o,
  output logic               dec_o,
  output logic [LEVEL_W-1:0] level,
  output logic               busy
);
  localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(MAX_LEVEL);
  localparam logic [TIMER_W-1:0] PULSE_LD = TIMER_W'(PULSE_W - 1);
  localparam logic [TIMER_W-1:0] GAP_LD = TIMER_W'(GAP_W - 1);
`ifdef PWM_SEQ_HOME_EN
  localparam state_t RST_STATE = HOME;
  localparam logic [LEVEL_W-1:0] RST_LEVEL = '0;
`else
  localparam state_t RST_STATE = IDLE;
  localparam logic [LEVEL_W-1:0] RST_LEVEL = LEVEL_W'(INIT_LEVEL);
`endif
  state_t state, state_n;
  logic [LEVEL_W-1:0] target, target_n, level_n, sat;
  logic dir, dir_n, load, done, homing;
  logic [TIMER_W-1:0] load_val;
  pwm_seq_timer u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .done(done)
  );
`ifdef PWM_SEQ_HOME_EN
  logic [LEVEL_W-1:0] home_left, home_n;
  always_comb home_n = state == HOME ? MAX_L :
                       (state == PULSE && done && homing) ? home_left - 1'b1 : home_left;
  always_ff @(posedge clk or posedge reset)
    if (reset) home_left <= '0;
    else home_left <= home_n;
  assign homing = home_left != '0;
`else
  assign homing = 1'b0;
`endif
  assign sat = tgt_level > MAX_L ? MAX_L : tgt_level;
  assign tgt_ready = state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    state_n  = state;
    dir_n    = dir;
    level_n  = level;
    target_n = target;
    load     = 1'b0;
    load_val = PULSE_LD;
    case (state)
      HOME: begin
        state_n = PULSE;
        dir_n   = 1'b0;
        load    = 1'b1;
      end
      IDLE: if (tgt_valid) begin
        target_n = sat;
        if (sat != level) begin
          state_n = PULSE;
          dir_n   = sat > level;
          load    = 1'b1;
        end
      end
      PULSE: if (done) begin
        level_n  = dir ? (level < MAX_L ? level + 1'b1 : level) : (level != '0 ? level - 1'b1 : level);
        state_n  = GAP;
        load     = 1'b1;
        load_val = GAP_LD;
      end
      GAP: if (done) begin
        state_n = (homing || level != target) ? PULSE : IDLE;
        dir_n   = homing ? 1'b0 : target > level;
        load    = state_n == PULSE;
      end
      default: state_n = RST_STATE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= RST_STATE;
      level  <= RST_LEVEL;
      target <= RST_LEVEL;
      dir    <= 1'b0;
      inc_o  <= 1'b0;
      dec_o  <= 1'b0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      target <= target_n;
      dir    <= dir_n;
      inc_o  <= state_n == PULSE && dir_n;
      dec_o  <= state_n == PULSE && !dir_n;
    end
endmodule

// File: tb/tb_pwm_seq.sv
// tb_pwm_seq: random level requests checked cycle by cycle against an arithmetic step-timing model
module tb_pwm_seq;
  import pwm_seq_pkg::*;
  localparam int MAXL = 10, INITL = 5, PW = 2, GW = 4, STEP = PW + GW;
  logic clk = 0, reset = 1, tgt_valid = 0, tgt_ready, inc_o, dec_o, busy;
  logic [LEVEL_W-1:0] tgt_level = '0, level;
  int n_cmp = 0, n_err = 0, mdl = INITL;
  pwm_seq dut (
    .clk(clk), .reset(reset), .tgt_level(tgt_level), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .inc_o(inc_o), .dec_o(dec_o), .level(level), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask
  task automatic run_req(input int t, input bit inj);
    int tt, n, start, lim, steps, pulses;
    bit up, pul, prev;
    tt = t > MAXL ? MAXL : t;
    start = mdl;
    up = tt > start;
    n = up ? tt - start : start - tt;
    lim = n * STEP + 3;
    @(negedge clk);
    check("rdy_pre", tgt_ready, 1);
    tgt_level = LEVEL_W'(t);
    tgt_valid = 1;
    @(posedge clk);
    pulses = 0;
    prev = 0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      tgt_valid = inj && k >= 2 && k < n * STEP;
      if (tgt_valid) tgt_level = LEVEL_W'($urandom_range(0, 15));
      pul = k <= n * STEP && (k - 1) % STEP < PW;
      steps = k < PW + 1 ? 0 : ((k - PW - 1) / STEP + 1 > n ? n : (k - PW - 1) / STEP + 1);
      check("inc", inc_o, up && pul);
      check("dec", dec_o, !up && pul);
      check("level", level, up ? start + steps : start - steps);
      check("ready", tgt_ready, k > n * STEP);
      check("busy", busy, k <= n * STEP);
      if ((inc_o | dec_o) && !prev) pulses++;
      prev = inc_o | dec_o;
    end
    check("pulses", pulses, n);
    mdl = tt;
  endtask
  initial begin
    int tt;
    #12;
    check("rst_level", level, INITL);
    check("rst_ready", tgt_ready, 1);
    check("rst_inc", inc_o, 0);
    check("rst_dec", dec_o, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 0;
    run_req(7, 0);
    run_req(15, 0);
    check("sat_level", level, MAXL);
    run_req(5, 0);
    run_req(5, 0);
    run_req(2, 1);
    for (int i = 0; i < 10; i++) run_req($urandom_range(0, 15), $urandom_range(0, 1));
    tt = mdl >= 5 ? 0 : MAXL;
    @(negedge clk);
    tgt_level = LEVEL_W'(tt);
    tgt_valid = 1;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 0;
    check("pre_rst_pulse", inc_o | dec_o, 1);
    #2 reset = 1;
    #1;
    check("async_inc", inc_o, 0);
    check("async_dec", dec_o, 0);
    @(negedge clk);
    reset = 0;
    mdl = INITL;
    check("post_rst_level", level, INITL);
    check("post_rst_ready", tgt_ready, 1);
    run_req(1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
